datapath_sequencer: RTL

Multi-cycle sequencer for the MIPS datapath. It replaces free-running fetch with a handshake-driven FETCH/EXEC/MEM/WB/HALT state machine. It latches the fetched instruction and load data, and gates PC and register-file writes so each architectural update happens exactly once per instruction regardless of cache latency. It sits between the datapath glue logic and the datapath-cache interface, and counts retired instructions.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/datapath_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the multi-cycle sequencer state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/datapath_sequencer.sv
// Handshake-driven FETCH/EXEC/MEM/WB/HALT sequencer gating PC and register-file writes.
// Optional request timeout enabled by DATAPATH_SEQUENCER_TIMEOUT_EN.
module datapath_sequencer
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              halt_in,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] instr_q,
    output logic [WORD_W-1:0] dload_q,
    output logic              pc_wen,
    output logic              rf_wen_gate,
    output logic              halt,
`ifdef DATAPATH_SEQUENCER_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic [CNT_W-1:0]  retired
);

    seq_state_t state, next_state;
    logic       waiting;
    logic       wait_expired;

    if (WAIT_MAX < 1) begin : g_wait_max_check
        $error("WAIT_MAX must be at least 1");
    end

    // A request is outstanding whenever FETCH/MEM sees no hit this cycle.
    assign waiting = ((state == FETCH) && !ihit) || ((state == MEM) && !dhit);

`ifdef DATAPATH_SEQUENCER_TIMEOUT_EN
    localparam int unsigned WAIT_W = ($clog2(WAIT_MAX + 1) > 8) ? $clog2(WAIT_MAX + 1) : 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    logic [WAIT_W-1:0] wait_cnt;

    // wait_cnt holds (cycles already spent waiting); the WAIT_MAX-th miss expires.
    assign wait_expired = waiting && (wait_cnt == WAIT_LAST);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
            if (wait_expired)
                timeout_err <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (ihit)
                    next_state = EXEC;
                else if (wait_expired)
                    next_state = HALT;
            end
            EXEC: begin
                if (halt_in)
                    next_state = HALT;
                else if (is_mem_op(mem_rd, mem_wr))
                    next_state = MEM;
                else
                    next_state = WB;
            end
            MEM: begin
                if (dhit)
                    next_state = WB;
                else if (wait_expired)
                    next_state = HALT;
            end
            WB:      next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        imemREN     = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        pc_wen      = 1'b0;
        rf_wen_gate = 1'b0;
        halt        = 1'b0;
        case (state)
            FETCH: imemREN = 1'b1;
            MEM: begin
                dmemWEN = mem_wr;
                dmemREN = mem_rd & ~mem_wr;
            end
            WB: begin
                pc_wen      = 1'b1;
                rf_wen_gate = 1'b1;
            end
            HALT:    halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            instr_q <= '0;
            dload_q <= '0;
            retired <= '0;
        end else begin
            if ((state == FETCH) && ihit)
                instr_q <= imemload;
            if ((state == MEM) && dhit && mem_rd && !mem_wr)
                dload_q <= dmemload;
            if (state == WB)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule
